timer_bank: RTL and testbench
=============================

Name: timer_bank

Overview:
- Parametrised bank of NUM_CH independent, runtime-programmable down-counter tick generators.
- Successor to the fixed CPU/60 Hz/VGA divider; replaces compile-time divider constants with per-channel reload values, periodic/one-shot modes, per-channel enable and a global phase-sync restart.
- Sits beside the CHIP-8 core: the channels drive the instruction-cycle strobe, the 60 Hz delay/sound strobe and the pixel-clock enable.
- Configured by the top level (or a debug port) through a single-cycle write port.

Parameters:
- NUM_CH, 4, number of channels (1..16).
- CNT_W, 32, counter and reload width in bits.
- IDX_W, $clog2(NUM_CH) with a minimum of 1, channel-index width (derived; not overridden).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  config write strobe, single cycle.
- cfg_ch  in  IDX_W  target channel index.
- cfg_top  in  CNT_W  reload value; period = cfg_top+1 cycles.
- cfg_mode  in  1  0 = periodic, 1 = one-shot.
- cfg_en  in  1  channel enable written with the config.
- sync_restart  in  1  reload every enabled channel simultaneously.
- tick  out  NUM_CH  registered one-cycle tick pulse per channel.
- active  out  NUM_CH  channel enabled.

Behaviour:
- Reset (async assert, sync release): all count, top, mode and en registers = 0; tick = 0; active = 0.
- Per-channel state: top, mode, en, count. active[i] = en[i]. All state is registered.
- Priority at each posedge, per channel, highest first:
  1. cfg_we && cfg_ch==i
  2. sync_restart
  3. normal count
- Config write to channel i:
  - top <= cfg_top, mode <= cfg_mode, en <= cfg_en.
  - count <= cfg_top if cfg_en, else 0.
  - tick[i] <= 0.
  - A write to a channel that is mid-count discards the old count; no tick is issued for the interrupted period.
- cfg_ch >= NUM_CH: write ignored; no state change in any channel.
- sync_restart (channel not being written):
  - Enabled channels: count <= top, tick <= 0.
  - Disabled channels are unaffected.
- Normal count, en=1:
  - count != 0: count <= count-1, tick <= 0.
  - count == 0, periodic: tick <= 1, count <= top.
  - count == 0, one-shot: tick <= 1, en <= 0, count stays 0.
- Normal count, en=0: count holds, tick <= 0.
- Timing:
  - First tick is high during the cycle following the (top+1)th edge after the config-write edge.
  - Periodic ticks then repeat every top+1 cycles. A tick is exactly 1 cycle wide.
- top == 0, periodic: tick held high every cycle from the 2nd cycle after the write onward.
- top == 2^CNT_W-1: no overflow. Count is strictly down with reload; no wrap below 0.
- Channels are fully independent apart from the shared write port and sync_restart.

Decomposition:
- Shared package timer_pkg:
  - MODE_PERIODIC = 1'b0, MODE_ONESHOT = 1'b1.
  - Default reload constants for the CPU (500 Hz), 60 Hz and VGA (25 MHz) channels, derived from the board clock-speed define.
- One sub-module, timer_channel: holds top/mode/en/count/tick for one channel and takes a decoded write-select. timer_bank instantiates NUM_CH of them in a generate loop, decodes cfg_ch and fans out sync_restart.

Test Plan:
- Reset mid-count: write ch0 top=9 en=1, assert rst_n=0 after 4 cycles -> tick=0, active=0 immediately; no tick for 30 cycles after release.
- Periodic: write ch1 top=4 periodic en=1 -> tick[1] high for 1 cycle on cycles 6, 11, 16 after the write edge; never high elsewhere.
- One-shot: write ch2 top=3 one-shot en=1 -> single tick[2] pulse on cycle 5; active[2] falls with the pulse; no further ticks over 50 cycles.
- top=0 and disable: write ch3 top=0 periodic en=1 -> tick[3] constantly 1 from cycle 2. Then write en=0 -> tick[3]=0 the next cycle; count holds 0.
- sync_restart alignment: ch0 top=7 and ch1 top=3 running with offset phases; pulse sync_restart -> both ticks land together 8 cycles later, then ch1 ticks every 4 and ch0 every 8 in phase. A disabled channel stays silent.
- Collision / out-of-range: cfg_we to ch1 top=2 in the same cycle as sync_restart -> ch1 takes top=2 and ticks 3 cycles later, while the other channels restart. A write with cfg_ch=NUM_CH (NUM_CH=3 build) changes nothing.

Source files
------------

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared mode encodings and default reload values for timer_bank.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef BOARD_CLK_HZ
`define BOARD_CLK_HZ 50_000_000
`endif

package timer_pkg;

    localparam int unsigned c_clk_hz = `BOARD_CLK_HZ;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // Reload value giving a tick rate of hz; clamps to every-cycle when hz >= clock.
    function automatic int unsigned calc_top(input int unsigned hz);
        if (hz == 0 || c_clk_hz <= hz) begin
            return 0;
        end
        return (c_clk_hz / hz) - 1;
    endfunction

    localparam int unsigned c_cpu_top  = calc_top(500);
    localparam int unsigned c_60hz_top = calc_top(60);
    localparam int unsigned c_vga_top  = calc_top(25_000_000);

endpackage : timer_pkg
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// ============================================================================
// Module      : timer_channel
// Description : One programmable down-counter tick generator (periodic/one-shot).
// Revision    : 1.0 - initial release
// ============================================================================
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_sel,
    input  logic [CNT_W-1:0] i_cfg_top,
    input  logic             i_cfg_mode,
    input  logic             i_cfg_en,
    input  logic             i_sync_restart,
    output logic             o_tick,
    output logic             o_active
);

    logic [CNT_W-1:0] r_top;
    logic [CNT_W-1:0] r_count;
    logic             r_mode;
    logic             r_en;
    logic             r_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_top   <= '0;
            r_count <= '0;
            r_mode  <= MODE_PERIODIC;
            r_en    <= 1'b0;
            r_tick  <= 1'b0;
        end else if (i_wr_sel) begin
            // A write always starts a fresh period; any count in flight is dropped.
            r_top   <= i_cfg_top;
            r_mode  <= i_cfg_mode;
            r_en    <= i_cfg_en;
            r_count <= i_cfg_en ? i_cfg_top : '0;
            r_tick  <= 1'b0;
        end else if (i_sync_restart && r_en) begin
            r_count <= r_top;
            r_tick  <= 1'b0;
        end else if (r_en) begin
            if (r_count != '0) begin
                r_count <= r_count - CNT_W'(1);
                r_tick  <= 1'b0;
            end else begin
                r_tick <= 1'b1;
                if (r_mode == MODE_ONESHOT) begin
                    r_en <= 1'b0;
                end else begin
                    r_count <= r_top;
                end
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign o_tick   = r_tick;
    assign o_active = r_en;

endmodule : timer_channel
`default_nettype wire

// File: rtl/timer_bank.sv
`default_nettype none
// ============================================================================
// Module      : timer_bank
// Description : Bank of NUM_CH runtime-programmable tick generators sharing one
//               config write port and a global phase-sync restart.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_bank
    import timer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0]  cfg_top,
    input  logic              cfg_mode,
    input  logic              cfg_en,
    input  logic              sync_restart,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] active
);

    logic [NUM_CH-1:0] w_wr_sel;

    // Indices at or above NUM_CH match no channel, so such writes fall away.
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign w_wr_sel[i] = cfg_we && (cfg_ch == IDX_W'(i));

            timer_channel #(
                .CNT_W (CNT_W)
            ) u_channel (
                .clk            (clk),
                .rst_n          (rst_n),
                .i_wr_sel       (w_wr_sel[i]),
                .i_cfg_top      (cfg_top),
                .i_cfg_mode     (cfg_mode),
                .i_cfg_en       (cfg_en),
                .i_sync_restart (sync_restart),
                .o_tick         (tick[i]),
                .o_active       (active[i])
            );
        end
    endgenerate

endmodule : timer_bank
`default_nettype wire

// File: tb/tb_timer_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_bank
// Description : Directed self-checking bench for timer_bank (4-ch/32-bit and
//               3-ch/4-bit builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_bank;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [31:0] cfg_top;
    logic        cfg_mode;
    logic        cfg_en;
    logic        sync_restart;
    logic [3:0]  tick;
    logic [3:0]  active;

    logic        cfg_we3;
    logic [1:0]  cfg_ch3;
    logic [3:0]  cfg_top3;
    logic        cfg_mode3;
    logic        cfg_en3;
    logic        sync3;
    logic [2:0]  tick3;
    logic [2:0]  active3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    timer_bank #(.NUM_CH(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_top(cfg_top), .cfg_mode(cfg_mode), .cfg_en(cfg_en),
        .sync_restart(sync_restart), .tick(tick), .active(active)
    );

    timer_bank #(.NUM_CH(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we3), .cfg_ch(cfg_ch3),
        .cfg_top(cfg_top3), .cfg_mode(cfg_mode3), .cfg_en(cfg_en3),
        .sync_restart(sync3), .tick(tick3), .active(active3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [31:0] top,
                      input logic mode, input logic en);
        cfg_we = 1'b1; cfg_ch = ch; cfg_top = top; cfg_mode = mode; cfg_en = en;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic wr3(input logic [1:0] ch, input logic [3:0] top,
                       input logic mode, input logic en);
        cfg_we3 = 1'b1; cfg_ch3 = ch; cfg_top3 = top; cfg_mode3 = mode; cfg_en3 = en;
        step();
        cfg_we3 = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (tick !== 4'b0 || active !== 4'b0 || tick3 !== 3'b0 || active3 !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_state: tick=%b active=%b tick3=%b active3=%b, want all 0",
                     tick, active, tick3, active3);
        end
        wr(2'd0, 32'd9, 1'b0, 1'b1);
        repeat (4) step();
        n_checks++;
        if (active !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_pre_active: active=%b, want 0001", active);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (tick !== 4'b0 || active !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_async: tick=%b active=%b, want 0000 0000", tick, active);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            n_checks++;
            if (tick !== 4'b0 || active !== 4'b0) begin
                n_fail++;
                $display("FAIL reset_quiet k=%0d: tick=%b active=%b, want 0000 0000", k, tick, active);
            end
        end
    endtask

    task automatic test_periodic();
        logic [3:0] exp_t;
        wr(2'd1, 32'd4, 1'b0, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_t = (k % 5 == 0) ? 4'b0010 : 4'b0000;
            n_checks++;
            if (tick !== exp_t || active !== 4'b0010) begin
                n_fail++;
                $display("FAIL periodic k=%0d: tick=%b active=%b, want %b 0010", k, tick, active, exp_t);
            end
        end
        wr(2'd1, 32'd4, 1'b0, 1'b0);
    endtask

    task automatic test_oneshot();
        logic [3:0] exp_t;
        logic [3:0] exp_a;
        wr(2'd2, 32'd3, 1'b1, 1'b1);
        for (int k = 1; k <= 50; k++) begin
            step();
            exp_t = (k == 4) ? 4'b0100 : 4'b0000;
            exp_a = (k < 4)  ? 4'b0100 : 4'b0000;
            n_checks++;
            if (tick !== exp_t || active !== exp_a) begin
                n_fail++;
                $display("FAIL oneshot k=%0d: tick=%b active=%b, want %b %b", k, tick, active, exp_t, exp_a);
            end
        end
    endtask

    task automatic test_top0_disable();
        wr(2'd3, 32'd0, 1'b0, 1'b1);
        n_checks++;
        if (tick !== 4'b0000) begin
            n_fail++;
            $display("FAIL top0_write_edge: tick=%b, want 0000", tick);
        end
        for (int k = 1; k <= 10; k++) begin
            step();
            n_checks++;
            if (tick !== 4'b1000 || active !== 4'b1000) begin
                n_fail++;
                $display("FAIL top0 k=%0d: tick=%b active=%b, want 1000 1000", k, tick, active);
            end
        end
        wr(2'd3, 32'd0, 1'b0, 1'b0);
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) step();
            n_checks++;
            if (tick !== 4'b0000 || active !== 4'b0000) begin
                n_fail++;
                $display("FAIL disable k=%0d: tick=%b active=%b, want 0000 0000", k, tick, active);
            end
        end
    endtask

    task automatic test_sync();
        logic [3:0] exp_t;
        wr(2'd0, 32'd7, 1'b0, 1'b1);
        repeat (3) step();
        wr(2'd1, 32'd3, 1'b0, 1'b1);
        repeat (2) step();
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        n_checks++;
        if (tick !== 4'b0000) begin
            n_fail++;
            $display("FAIL sync_edge: tick=%b, want 0000", tick);
        end
        for (int k = 1; k <= 24; k++) begin
            step();
            exp_t = {2'b00, (k % 4 == 0), (k % 8 == 0)};
            n_checks++;
            if (tick !== exp_t || active !== 4'b0011) begin
                n_fail++;
                $display("FAIL sync k=%0d: tick=%b active=%b, want %b 0011", k, tick, active, exp_t);
            end
        end
    endtask

    task automatic test_collision();
        logic [3:0] exp_t;
        sync_restart = 1'b1;
        wr(2'd1, 32'd2, 1'b0, 1'b1);
        sync_restart = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            step();
            exp_t = {2'b00, (k % 3 == 0), (k % 8 == 0)};
            n_checks++;
            if (tick !== exp_t || active !== 4'b0011) begin
                n_fail++;
                $display("FAIL collision k=%0d: tick=%b active=%b, want %b 0011", k, tick, active, exp_t);
            end
        end
        wr(2'd0, 32'd0, 1'b0, 1'b0);
        wr(2'd1, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_out_of_range();
        logic [2:0] exp_t;
        wr3(2'd0, 4'd2, 1'b0, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            if (k == 4) begin
                cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_top3 = 4'd5; cfg_mode3 = 1'b1; cfg_en3 = 1'b0;
            end else begin
                cfg_we3 = 1'b0;
            end
            step();
            exp_t = (k % 3 == 0) ? 3'b001 : 3'b000;
            n_checks++;
            if (tick3 !== exp_t || active3 !== 3'b001) begin
                n_fail++;
                $display("FAIL out_of_range k=%0d: tick3=%b active3=%b, want %b 001", k, tick3, active3, exp_t);
            end
        end
        cfg_we3 = 1'b0;
        wr3(2'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_max_top();
        logic [2:0] exp_t;
        wr3(2'd1, 4'd15, 1'b0, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            step();
            exp_t = (k % 16 == 0) ? 3'b010 : 3'b000;
            n_checks++;
            if (tick3 !== exp_t || active3 !== 3'b010) begin
                n_fail++;
                $display("FAIL max_top k=%0d: tick3=%b active3=%b, want %b 010", k, tick3, active3, exp_t);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_top = '0; cfg_mode = 1'b0; cfg_en = 1'b0;
        sync_restart = 1'b0;
        cfg_we3 = 1'b0; cfg_ch3 = '0; cfg_top3 = '0; cfg_mode3 = 1'b0; cfg_en3 = 1'b0;
        sync3 = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        test_reset();
        test_periodic();
        test_oneshot();
        test_top0_disable();
        test_sync();
        test_collision();
        test_out_of_range();
        test_max_top();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_timer_bank
`default_nettype wire
